// File: rtl/plug_pkg.sv
// Shared types and constants for the programmable plugboard.
// Holds the default pair table used when PLUG_DEFAULT_EN is defined.
package plug_pkg;

  localparam int unsigned LETTER_W    = 5;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned NUM_LETTERS = 26;

  typedef logic [LETTER_W-1:0] letter_t;

  localparam letter_t LETTER_MIN = 5'd1;
  localparam letter_t LETTER_MAX = 5'd26;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    WRITE = 2'd2,
    CLEAR = 2'd3
  } state_t;

  typedef struct packed {
    letter_t a;
    letter_t b;
  } pair_t;

  localparam int unsigned DEF_PAIR_NUM = 6;

  // a-b, k-m, l-y, e-u, o-p, r-s
  localparam pair_t DEF_PAIRS [DEF_PAIR_NUM] = '{
    '{5'd1,  5'd2},
    '{5'd11, 5'd13},
    '{5'd12, 5'd25},
    '{5'd5,  5'd21},
    '{5'd15, 5'd16},
    '{5'd18, 5'd19}
  };

  function automatic letter_t default_partner(letter_t x);
    letter_t p;
    p = x;
    for (int unsigned i = 0; i < DEF_PAIR_NUM; i++) begin
      if (DEF_PAIRS[i].a == x) p = DEF_PAIRS[i].b;
      else if (DEF_PAIRS[i].b == x) p = DEF_PAIRS[i].a;
    end
    return p;
  endfunction

endpackage

// File: rtl/plugboard_prog.sv
// Programmable plugboard: letter substitution through a run-time configurable involution map.
// Define PLUG_DEFAULT_EN to come out of reset with the default six-pair wiring.
module plugboard_prog
  import plug_pkg::*;
#(
  parameter int unsigned MAX_PAIRS = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  input  logic [LETTER_W-1:0] cfg_a,
  input  logic [LETTER_W-1:0] cfg_b,
  input  logic                cfg_clear,
  output logic                cfg_ready,
  output logic                cfg_err,
  output logic [CNT_W-1:0]    pair_cnt,
  input  logic                in_valid,
  input  logic [LETTER_W-1:0] in_letter,
  output logic                in_ready,
  output logic                out_valid,
  output logic [LETTER_W-1:0] out_letter,
  input  logic                out_ready
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PAIRS);

`ifdef PLUG_DEFAULT_EN
  localparam logic [CNT_W-1:0] RESET_CNT = CNT_W'(DEF_PAIR_NUM);
`else
  localparam logic [CNT_W-1:0] RESET_CNT = '0;
`endif

  function automatic letter_t reset_entry(letter_t x);
`ifdef PLUG_DEFAULT_EN
    return default_partner(x);
`else
    return x;
`endif
  endfunction

  state_t  state;
  state_t  state_n;
  letter_t map_q [1:NUM_LETTERS];
  letter_t cfg_a_q;
  letter_t cfg_b_q;
  letter_t clr_idx;
  letter_t sub_c;
  logic    reject_c;
  logic    accept_c;

  // Pair legality for the latched request.
  always_comb begin
    reject_c = (cfg_a_q == cfg_b_q) || (pair_cnt == MAX_CNT);
    if (cfg_a_q < LETTER_MIN || cfg_a_q > LETTER_MAX) reject_c = 1'b1;
    else if (map_q[cfg_a_q] != cfg_a_q) reject_c = 1'b1;
    if (cfg_b_q < LETTER_MIN || cfg_b_q > LETTER_MAX) reject_c = 1'b1;
    else if (map_q[cfg_b_q] != cfg_b_q) reject_c = 1'b1;
  end

  // Substitution lookup; out-of-range codes pass straight through.
  always_comb begin
    sub_c = in_letter;
    if (in_letter >= LETTER_MIN && in_letter <= LETTER_MAX) sub_c = map_q[in_letter];
  end

  assign in_ready = ((state == IDLE) || (state == CHECK)) && (!out_valid || out_ready);
  assign accept_c = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (cfg_clear)      state_n = CLEAR;
        else if (cfg_valid) state_n = CHECK;
      end
      CHECK:   state_n = reject_c ? IDLE : WRITE;
      WRITE:   state_n = IDLE;
      CLEAR:   if (clr_idx == LETTER_MAX) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Map, counters and config-side outputs; a reset simply reloads everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 1; i <= NUM_LETTERS; i++) begin
        map_q[LETTER_W'(i)] <= reset_entry(LETTER_W'(i));
      end
      pair_cnt  <= RESET_CNT;
      cfg_a_q   <= '0;
      cfg_b_q   <= '0;
      clr_idx   <= LETTER_MIN;
      cfg_err   <= 1'b0;
      cfg_ready <= 1'b1;
    end else begin
      cfg_err   <= (state == CHECK) && reject_c;
      cfg_ready <= (state_n == IDLE);
      unique case (state)
        IDLE: begin
          clr_idx <= LETTER_MIN;
          if (!cfg_clear && cfg_valid) begin
            cfg_a_q <= cfg_a;
            cfg_b_q <= cfg_b;
          end
        end
        WRITE: begin
          map_q[cfg_a_q] <= cfg_b_q;
          map_q[cfg_b_q] <= cfg_a_q;
          pair_cnt       <= pair_cnt + CNT_W'(1);
        end
        CLEAR: begin
          map_q[clr_idx] <= clr_idx;
          clr_idx        <= clr_idx + LETTER_W'(1);
          if (clr_idx == LETTER_MAX) pair_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  // One-entry output register with hold under backpressure.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_letter <= '0;
    end else if (accept_c) begin
      out_valid  <= 1'b1;
      out_letter <= sub_c;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule
